fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID register whose `ifid_instr[31:26]` drives the opcode decoder. It resolves next-PC selection from the decoder's `jump` and the branch-resolution stage's `br_eq`/`br_ne`/`alu_zero`. It absorbs hazard stalls with a one-entry skid buffer and flushes on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset (bits [1:0] must be 0).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request, level; held until `imem_ack`.
- `imem_addr` out 32: fetch address, stable while `imem_req`=1.
- `imem_rdata` in 32: instruction, valid when `imem_ack`=1.
- `imem_ack` in 1: completes the current request; may be high in the same cycle as `imem_req` (zero-wait memory).
- `stall` in 1: hazard hold of the IF/ID register.
- `jump` in 1: decoder jump for the instruction in IF/ID.
- `br_eq`, `br_ne`, `alu_zero` in 1 each: branch resolution for the older instruction.
- `br_target` in 32: branch target for the older instruction.
- `ifid_instr` out 32: fetched instruction; NOP (32'h0) when invalid.
- `ifid_pc4` out 32: PC+4 of `ifid_instr`.
- `ifid_valid` out 1: IF/ID holds a real instruction.

## Operation
- `br_take` = (`br_eq` & `alu_zero`) | (`br_ne` & ~`alu_zero`).
- `j_take` = `jump` & `ifid_valid`.
- `redirect` = `br_take` | `j_take`.
- Target priority: `br_take` over `j_take`; the branch is the older instruction.
  - Branch target: `br_target` with bits [1:0] forced to 0.
  - Jump target: {`ifid_pc4`[31:28], `ifid_instr`[25:0], 2'b00}.
- PC+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0.
- FSM states: IDLE, FETCH, BUFFERED, KILL. `imem_req`=1 only in FETCH and KILL; `imem_addr`=`pc`.
- IDLE: entered on reset; goes to FETCH on the next edge.
- FETCH, `imem_ack` & ~`stall`: IF/ID <= {`imem_rdata`, `pc`+4, valid=1}; `pc` <= `pc`+4; stay in FETCH.
- FETCH, `imem_ack` & `stall`: IF/ID held; `buf` <= {`imem_rdata`, `pc`+4}; `pc` <= `pc`+4; go to BUFFERED.
- FETCH, ~`imem_ack` & ~`stall`: IF/ID <= bubble (NOP, valid=0).
- FETCH, ~`imem_ack` & `stall`: IF/ID held.
- BUFFERED: no request. When `stall` drops, IF/ID <= `buf` with valid=1 and the state returns to FETCH.
- Redirect has priority over stall and over all of the above:
  - IF/ID <= bubble; `buf` discarded; `pc` <= target.
  - Request outstanding without ack (FETCH, ~`imem_ack`): go to KILL; the old address stays on `imem_addr` until ack.
  - Otherwise: go to FETCH.
- KILL: keeps requesting the old address. On `imem_ack` the data is dropped and the state goes to FETCH at the redirected PC. A second redirect in KILL overwrites the pending target.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=IDLE.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0.
  - `buf`=0.
- First request: the cycle after the first edge with `rst_n`=1.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- Fetch latency: request cycle to IF/ID valid = ack cycle + 1 edge.
- Redirect penalty:
  - Jump: 1 bubble.
  - Branch: bubble in IF/ID; the new address appears the cycle after redirect (no outstanding request) or after the KILL ack.
- Reset mid-request: state and outputs return to reset values immediately. Any late `imem_ack` is ignored because the state is IDLE.

## Structure
- Package `mips_pkg` holds:
  - opcode constants (J=6'b000010, BEQ=6'b000100, BNE=6'b000101),
  - `NOP`=32'h0,
  - default `RESET_PC`,
  - the fetch FSM state enum.
- Sub-module `pc_next_sel`: combinational computation of `redirect` and target, and `pc`+4. FSM, PC, skid buffer and IF/ID live in `fetch_stage`.

## Test plan
- Zero-wait memory, `imem_ack`=`imem_req`, from reset: addresses 0,4,8,12 on consecutive cycles; `ifid_pc4` 4,8,12,16, one cycle later each.
- `stall` high 3 cycles with ack arriving during the stall: exactly one buffered word; no address skipped or repeated. `ifid_instr` holds, then the buffered word appears the cycle after `stall` falls.
- IF/ID holds 32'h0800_0040 (j) with `ifid_pc4`=32'h0000_0010: next address 32'h0000_0100; IF/ID bubble for one cycle.
- `br_eq`=1, `alu_zero`=1, `br_target`=32'h200, plus `j_take` in the same cycle: branch wins; next fetch at 32'h200.
- Memory with 3-cycle latency, redirect to 32'h80 in cycle 1 of a request: old address held until ack, its data dropped, next request at 32'h80, no stale `ifid_valid`.
- `pc`=32'hFFFF_FFFC fetched: next address 32'h0. `rst_n` pulsed mid-request: all outputs return to reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, NOP, default reset PC and the
// fetch FSM state encoding.
package mips_pkg;

  localparam logic [5:0]  OP_J   = 6'b000010;
  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_BUFFERED = 2'd2,
    ST_KILL     = 2'd3
  } fetch_state_e;

  // J-format target: upper nibble of the delay-slot PC joined with the word index.
  function automatic logic [31:0] jump_target(input logic [3:0] pc4_hi, input logic [25:0] index);
    return {pc4_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential PC+4, jump and branch redirect.
// The branch belongs to the older instruction, so it outranks the jump.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic        ifid_valid,
  input  logic [25:0] ifid_index,
  input  logic [3:0]  ifid_pc4_hi,
  input  logic        br_eq,
  input  logic        br_ne,
  input  logic        alu_zero,
  input  logic [31:0] br_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  logic br_take_s;
  logic j_take_s;

  // Resolve taken branch/jump and pick the redirect target.
  always_comb begin
    br_take_s = (br_eq & alu_zero) | (br_ne & ~alu_zero);
    j_take_s  = jump & ifid_valid;
    redirect  = br_take_s | j_take_s;
    pc_plus4  = pc + 32'd4;
    if (br_take_s) begin
      target = br_target & 32'hFFFF_FFFC;
    end else if (j_take_s) begin
      target = jump_target(ifid_pc4_hi, ifid_index);
    end else begin
      target = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request FSM, one-entry skid buffer
// for hazard stalls and the IF/ID pipeline register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        jump,
  input  logic        br_eq,
  input  logic        br_ne,
  input  logic        alu_zero,
  input  logic [31:0] br_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  buf_instr_r, buf_instr_nxt_s;
  logic [31:0]  buf_pc4_r, buf_pc4_nxt_s;
  logic [31:0]  ifid_instr_r, ifid_instr_nxt_s;
  logic [31:0]  ifid_pc4_r, ifid_pc4_nxt_s;
  logic         ifid_valid_r, ifid_valid_nxt_s;
  logic         imem_req_r;
  logic [31:0]  imem_addr_r;
  logic         redirect_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;

  pc_next_sel u_pc_next_sel (
    .pc          (pc_r),
    .jump        (jump),
    .ifid_valid  (ifid_valid_r),
    .ifid_index  (ifid_instr_r[25:0]),
    .ifid_pc4_hi (ifid_pc4_r[31:28]),
    .br_eq       (br_eq),
    .br_ne       (br_ne),
    .alu_zero    (alu_zero),
    .br_target   (br_target),
    .redirect    (redirect_s),
    .target      (target_s),
    .pc_plus4    (pc_plus4_s)
  );

  // Next-state, PC, skid buffer and IF/ID update; redirect overrides everything.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    buf_instr_nxt_s  = buf_instr_r;
    buf_pc4_nxt_s    = buf_pc4_r;
    ifid_instr_nxt_s = ifid_instr_r;
    ifid_pc4_nxt_s   = ifid_pc4_r;
    ifid_valid_nxt_s = ifid_valid_r;
    if (redirect_s) begin
      pc_nxt_s         = target_s;
      buf_instr_nxt_s  = NOP;
      buf_pc4_nxt_s    = 32'h0000_0000;
      ifid_instr_nxt_s = NOP;
      ifid_pc4_nxt_s   = 32'h0000_0000;
      ifid_valid_nxt_s = 1'b0;
      // An un-acked request cannot be withdrawn; wait it out in KILL.
      if ((state_r == ST_FETCH || state_r == ST_KILL) && !imem_ack) begin
        state_nxt_s = ST_KILL;
      end else begin
        state_nxt_s = ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            pc_nxt_s = pc_plus4_s;
            if (stall) begin
              buf_instr_nxt_s = imem_rdata;
              buf_pc4_nxt_s   = pc_plus4_s;
              state_nxt_s     = ST_BUFFERED;
            end else begin
              ifid_instr_nxt_s = imem_rdata;
              ifid_pc4_nxt_s   = pc_plus4_s;
              ifid_valid_nxt_s = 1'b1;
            end
          end else if (!stall) begin
            ifid_instr_nxt_s = NOP;
            ifid_pc4_nxt_s   = 32'h0000_0000;
            ifid_valid_nxt_s = 1'b0;
          end else begin
            ifid_valid_nxt_s = ifid_valid_r;
          end
        end
        ST_BUFFERED: begin
          if (!stall) begin
            ifid_instr_nxt_s = buf_instr_r;
            ifid_pc4_nxt_s   = buf_pc4_r;
            ifid_valid_nxt_s = 1'b1;
            state_nxt_s      = ST_FETCH;
          end else begin
            state_nxt_s = ST_BUFFERED;
          end
        end
        ST_KILL: begin
          if (imem_ack) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_KILL;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; the request address is frozen while a killed fetch drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      buf_instr_r  <= NOP;
      buf_pc4_r    <= 32'h0000_0000;
      ifid_instr_r <= NOP;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= RESET_PC;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      buf_instr_r  <= buf_instr_nxt_s;
      buf_pc4_r    <= buf_pc4_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_pc4_r   <= ifid_pc4_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
      imem_req_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_KILL);
      imem_addr_r  <= (state_nxt_s == ST_KILL) ? imem_addr_r : pc_nxt_s;
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc4   = ifid_pc4_r;
  assign ifid_valid = ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// stall/latency run checked against an in-order program-stream model.
module tb_fetch_stage;

  localparam logic [31:0] J_WORD = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall, jump, br_eq, br_ne, alu_zero;
  logic [31:0] br_target;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;

  logic        j_en = 1'b0;
  logic        ack_force = 1'b0;
  logic        rand_lat = 1'b0;
  logic [1:0]  lat_cfg = 2'd0;
  logic [1:0]  wait_cnt = 2'd0;
  logic [31:0] mem_salt = 32'h8000_0001;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .stall      (stall),
    .jump       (jump),
    .br_eq      (br_eq),
    .br_ne      (br_ne),
    .alu_zero   (alu_zero),
    .br_target  (br_target),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: content derived from the address, ack after wait_cnt cycles.
  assign imem_rdata = (j_en && imem_addr == 32'h0000_000C) ? J_WORD : (imem_addr ^ mem_salt);
  assign imem_ack   = ack_force | (imem_req & (wait_cnt == 2'd0));

  always @(posedge clk) begin
    if (!rst_n) wait_cnt <= lat_cfg;
    else if (imem_req && imem_ack) wait_cnt <= rand_lat ? 2'($urandom_range(0, 2)) : lat_cfg;
    else if (imem_req && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
  end

  function automatic logic [31:0] mem_exp(input logic [31:0] a);
    if (j_en && a == 32'h0000_000C) return J_WORD;
    return a ^ mem_salt;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; jump = 1'b0; br_eq = 1'b0; br_ne = 1'b0; alu_zero = 1'b0;
    br_target = 32'h0;
  endtask

  // Hold reset for two edges, release, and stop #1 after the first live edge.
  task automatic do_reset(input logic [1:0] lat);
    lat_cfg = lat;
    clear_ctl();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    clear_ctl();
    rst_n = 1'b0;
    repeat (2) cyc();
    n_cmp++;
    if ({imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got req=%b addr=%h instr=%h pc4=%h v=%b want all zero",
               imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
    rst_n = 1'b1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_noreq: got req=%b want 0", imem_req);
    end
    cyc();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL first_req: got %b/%h want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset(2'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        n_bad++; $display("FAIL zw_addr%0d: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * i));
      end
      cyc();
      n_cmp++;
      if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, mem_exp(32'(4 * i)), 32'(4 * i + 4)}) begin
        n_bad++; $display("FAIL zw_ifid%0d: got %b/%h/%h want 1/%h/%h", i, ifid_valid, ifid_instr,
                          ifid_pc4, mem_exp(32'(4 * i)), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(2'd0);
    repeat (2) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if ({imem_req, ifid_valid, ifid_instr, ifid_pc4} !== {1'b0, 1'b1, mem_exp(32'h4), 32'h8}) begin
        n_bad++; $display("FAIL stall_hold%0d: got req=%b %b/%h/%h want 0 1/%h/00000008", i,
                          imem_req, ifid_valid, ifid_instr, ifid_pc4, mem_exp(32'h4));
      end
    end
    stall = 1'b0;
    cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr} !== {1'b1, mem_exp(32'h8), 32'hC, 1'b1, 32'hC}) begin
      n_bad++; $display("FAIL stall_release: got %b/%h/%h req=%b addr=%h want 1/%h/0000000c 1/0000000c",
                        ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr, mem_exp(32'h8));
    end
    cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, mem_exp(32'hC), 32'h10}) begin
      n_bad++; $display("FAIL stall_next: got %b/%h/%h want 1/%h/00000010", ifid_valid, ifid_instr,
                        ifid_pc4, mem_exp(32'hC));
    end
  endtask

  task automatic test_jump();
    j_en = 1'b1;
    do_reset(2'd0);
    repeat (4) cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, J_WORD, 32'h10}) begin
      n_bad++; $display("FAIL j_setup: got %b/%h/%h want 1/%h/00000010", ifid_valid, ifid_instr, ifid_pc4, J_WORD);
    end
    jump = 1'b1;
    cyc();
    jump = 1'b0;
    n_cmp++;
    if ({ifid_valid, ifid_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h100}) begin
      n_bad++; $display("FAIL j_redirect: got v=%b instr=%h req=%b addr=%h want 0/0 1/00000100",
                        ifid_valid, ifid_instr, imem_req, imem_addr);
    end
    cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, mem_exp(32'h100), 32'h104}) begin
      n_bad++; $display("FAIL j_target_data: got %b/%h/%h want 1/%h/00000104", ifid_valid, ifid_instr,
                        ifid_pc4, mem_exp(32'h100));
    end
    j_en = 1'b0;
  endtask

  task automatic test_branch();
    j_en = 1'b1;
    do_reset(2'd0);
    repeat (4) cyc();
    jump = 1'b1; br_eq = 1'b1; alu_zero = 1'b1; br_target = 32'h200;
    cyc();
    clear_ctl();
    n_cmp++;
    if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      n_bad++; $display("FAIL br_over_j: got v=%b req=%b addr=%h want 0 1/00000200", ifid_valid, imem_req, imem_addr);
    end
    cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, mem_exp(32'h200), 32'h204}) begin
      n_bad++; $display("FAIL br_data: got %b/%h/%h want 1/%h/00000204", ifid_valid, ifid_instr, ifid_pc4, mem_exp(32'h200));
    end
    br_ne = 1'b1; alu_zero = 1'b1; br_target = 32'h500;
    cyc();
    n_cmp++;
    if ({ifid_valid, imem_addr} !== {1'b1, 32'h208}) begin
      n_bad++; $display("FAIL bne_not_taken: got v=%b addr=%h want 1/00000208", ifid_valid, imem_addr);
    end
    alu_zero = 1'b0; br_target = 32'h303;
    cyc();
    clear_ctl();
    n_cmp++;
    if ({ifid_valid, imem_addr} !== {1'b0, 32'h300}) begin
      n_bad++; $display("FAIL bne_taken_align: got v=%b addr=%h want 0/00000300", ifid_valid, imem_addr);
    end
    j_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(2'd0);
    br_eq = 1'b1; alu_zero = 1'b1; br_target = 32'hFFFF_FFFF;
    cyc();
    clear_ctl();
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_top: got addr=%h want fffffffc", imem_addr);
    end
    cyc();
    n_cmp++;
    if ({imem_addr, ifid_valid, ifid_instr, ifid_pc4} !== {32'h0, 1'b1, mem_exp(32'hFFFF_FFFC), 32'h0}) begin
      n_bad++; $display("FAIL wrap_next: got addr=%h %b/%h/%h want 0 1/%h/00000000", imem_addr,
                        ifid_valid, ifid_instr, ifid_pc4, mem_exp(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_kill();
    do_reset(2'd2);
    br_eq = 1'b1; alu_zero = 1'b1; br_target = 32'h80;
    cyc();
    clear_ctl();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin
        n_bad++; $display("FAIL kill_hold%0d: got req=%b addr=%h v=%b want 1/00000000/0", i, imem_req, imem_addr, ifid_valid);
      end
      cyc();
    end
    n_cmp++;
    if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h80, 1'b0}) begin
      n_bad++; $display("FAIL kill_new_req: got req=%b addr=%h v=%b want 1/00000080/0", imem_req, imem_addr, ifid_valid);
    end
    repeat (2) begin
      cyc();
      n_cmp++;
      if (ifid_valid !== 1'b0) begin
        n_bad++; $display("FAIL kill_stale_valid: got v=%b want 0", ifid_valid);
      end
    end
    cyc();
    n_cmp++;
    if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, mem_exp(32'h80), 32'h84}) begin
      n_bad++; $display("FAIL kill_data: got %b/%h/%h want 1/%h/00000084", ifid_valid, ifid_instr, ifid_pc4, mem_exp(32'h80));
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'd2);
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL rst_mid: got req=%b addr=%h instr=%h pc4=%h v=%b want all zero",
                        imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid);
    end
    ack_force = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    ack_force = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL rst_late_ack: got req=%b addr=%h v=%b want 1/00000000/0", imem_req, imem_addr, ifid_valid);
    end
  endtask

  // Random stall and memory latency: issued and delivered streams must be 0,4,8,...
  task automatic test_random();
    logic [31:0] exp_issue, exp_del, p_addr, p_instr, p_pc4;
    logic        p_req, p_ack, p_stall, p_valid;
    int          n_del;
    exp_issue = 32'h0; exp_del = 32'h0; n_del = 0;
    rand_lat = 1'b1;
    do_reset(2'd0);
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      #1;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_stall = stall;
      p_instr = ifid_instr; p_pc4 = ifid_pc4; p_valid = ifid_valid;
      if (p_req && p_ack) begin
        n_cmp++;
        if (p_addr !== exp_issue) begin
          n_bad++; $display("FAIL rnd_issue: cycle %0d got addr=%h want %h", i, p_addr, exp_issue);
        end
        exp_issue = exp_issue + 32'd4;
      end
      cyc();
      if (p_req && !p_ack) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
          n_bad++; $display("FAIL rnd_addr_stable: cycle %0d got %b/%h want 1/%h", i, imem_req, imem_addr, p_addr);
        end
      end
      if (p_stall) begin
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {p_valid, p_instr, p_pc4}) begin
          n_bad++; $display("FAIL rnd_stall_hold: cycle %0d got %b/%h/%h want %b/%h/%h", i,
                            ifid_valid, ifid_instr, ifid_pc4, p_valid, p_instr, p_pc4);
        end
      end else if (ifid_valid) begin
        n_cmp++;
        if ({ifid_instr, ifid_pc4} !== {mem_exp(exp_del), exp_del + 32'd4}) begin
          n_bad++; $display("FAIL rnd_deliver: cycle %0d got %h/%h want %h/%h", i, ifid_instr,
                            ifid_pc4, mem_exp(exp_del), exp_del + 32'd4);
        end
        exp_del = exp_del + 32'd4;
        n_del++;
      end
    end
    stall = 1'b0;
    rand_lat = 1'b0;
    n_cmp++;
    if (n_del < 50) begin
      n_bad++; $display("FAIL rnd_progress: got %0d deliveries want at least 50", n_del);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_ctl();
    mem_salt = $urandom | 32'h8000_0001;
    test_reset();
    test_zero_wait();
    test_stall();
    test_jump();
    test_branch();
    test_wrap();
    test_kill();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
